alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Port clk, input, 1: single rising-edge clock for all state.
REQ-002 Port rst, input, 1: asynchronous, active-high reset.
REQ-003 Port cmd_valid, input, 1: command present.
REQ-004 Port cmd_ready, output, 1: sequencer accepts command; transfer occurs when cmd_valid && cmd_ready at clk edge.
REQ-005 Ports cmd_op input 4 (ALU opcode); cmd_rd, cmd_rs1, cmd_rs2 input 2 each (register indices); cmd_ld input 1 (load-immediate); cmd_imm input 8.
REQ-006 Ports alu_a output 8, alu_b output 8, alu_op output 4: operands and opcode driven to the external combinational 8-bit ALU.
REQ-007 Port alu_out, input, 8: combinational ALU result.
REQ-008 Ports res_valid output 1, res_ready input 1, res_data output 8, res_rd output 2: result handshake, transfer when res_valid && res_ready at clk edge.
REQ-009 Port op_count, output, 8: number of completed commands, modulo 256.

Function
REQ-010 Register file SHALL be 4 x 8-bit (r0-r3), internal, all writable.
REQ-011 FSM SHALL have states IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-012 Accept at edge ending cycle T with cmd_ld=0: alu_a<=rf[rs1], alu_b<=rf[rs2], alu_op<=cmd_op, res_rd<=cmd_rd; state->EXEC.
REQ-013 In EXEC (cycle T+1): rf[rd]<=alu_out, res_data<=alu_out at end of cycle; state->RESP; res_valid=1 from cycle T+2.
REQ-014 Accept with cmd_ld=1: rf[rd]<=cmd_imm, res_data<=cmd_imm, res_rd<=cmd_rd; state->RESP directly; res_valid=1 from T+1; alu_a/b/op unchanged.
REQ-015 Operand reads SHALL use register values before the write of the same command (rs==rd allowed).
REQ-016 In RESP, res_valid=1 and res_data/res_rd SHALL stay stable until res_ready=1; on transfer state->IDLE, op_count increments (255 wraps to 0); cmd_ready=1 the following cycle.
REQ-017 cmd_valid in EXEC/RESP SHALL be ignored with no state change; the upstream holds the command.
REQ-018 alu_a, alu_b, alu_op SHALL be registered and change only on a non-load accept.
REQ-019 Opcode encoding (decided): 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 pass-a, 9 pass-b, 10 shl, 11 srl, 12 sra, 13 inc4, 14 dec4, 15 popcount; the sequencer SHALL pass opcodes unmodified.

Reset
REQ-020 rst=1 SHALL immediately force state IDLE, rf all 0, alu_a=alu_b=0, alu_op=0, res_data=0, res_rd=0, res_valid=0, op_count=0; cmd_ready=1 after rst deasserts.
REQ-021 Reset during EXEC or RESP SHALL abandon the command with no result and no op_count increment.

Structure
REQ-022 Opcode constants and FSM state encoding SHALL live in shared package alu_pkg.
REQ-023 Register file SHALL be sub-module alu_regfile (2 async read ports, 1 sync write port, async reset).
REQ-024 The ALU itself SHALL be external; the bench SHALL connect the team's 8-bit ALU.

Verification
REQ-025 LD r0=5, LD r1=3, ADD r2=r0+r1 -> res_data=0x08, res_rd=2, res_valid 2 cycles after ADD accept.
REQ-026 SUB r3=r1-r0 (3-5) -> res_data=0xFE; then LD r0=0x81, SRA r0=r0 by rf[r1]=3 -> 0xF0.
REQ-027 res_ready low 5 cycles in RESP -> res_valid held, res_data stable, cmd_ready=0, new cmd_valid ignored.
REQ-028 Assert rst in EXEC -> all outputs 0 same cycle, no result, op_count=0, rf cleared.
REQ-029 256 back-to-back LD commands with res_ready=1 -> op_count wraps to 0; each command occupies 2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU sequencer slice.
//   - data/register-file geometry
//   - ALU opcode encoding; the sequencer forwards these unmodified to the external ALU
//   - sequencer FSM state encoding
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_CNT = 4;
    localparam int ADDR_W  = 2;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] OP_ADD    = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL    = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV    = 4'd3;
    localparam logic [OP_W-1:0] OP_AND    = 4'd4;
    localparam logic [OP_W-1:0] OP_OR     = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR    = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT    = 4'd7;
    localparam logic [OP_W-1:0] OP_PASS_A = 4'd8;
    localparam logic [OP_W-1:0] OP_PASS_B = 4'd9;
    localparam logic [OP_W-1:0] OP_SHL    = 4'd10;
    localparam logic [OP_W-1:0] OP_SRL    = 4'd11;
    localparam logic [OP_W-1:0] OP_SRA    = 4'd12;
    localparam logic [OP_W-1:0] OP_INC4   = 4'd13;
    localparam logic [OP_W-1:0] OP_DEC4   = 4'd14;
    localparam logic [OP_W-1:0] OP_POPCNT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, ALU and result signals of the sequencer.
//   cmd_*  : command channel into the sequencer
//   alu_*  : operands/opcode out to the external combinational ALU, alu_out back
//   res_*  : result channel out of the sequencer
//   op_count : completed-command counter (mod 256)
// Modports: slave = the sequencer, master = its environment (upstream,
// downstream and ALU).
//
// Handshake: a channel transfers on a rising clk edge where valid && ready.
// The source holds valid and its payload stable until that edge; ready may
// depend on the sink's state but never on valid in the same cycle.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic              cmd_ld;
    logic [DATA_W-1:0] cmd_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_out;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_rd;

    logic [7:0]        op_count;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_ld, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  res_valid, res_data, res_rd,
        output res_ready,
        input  op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_ld, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output res_valid, res_data, res_rd,
        input  res_ready,
        output op_count
    );

endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 4 x 8-bit register file.
//   clk, rst : clock, asynchronous active-high reset (clears all registers)
//   ra1/rd1, ra2/rd2 : two asynchronous read ports
//   we, wa, wd : synchronous write port
// Reads return the value before a same-cycle write lands.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [REG_CNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time, runs it through the
// external combinational ALU (or loads an immediate), writes the result to
// the register file and presents it on the result channel.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : alu_sequencer_if.slave (command, ALU, result, op_count)
//   state_dbg : current FSM state
// Timing: ALU command accepted at edge T -> EXEC -> result valid from T+2.
//         Load command accepted at edge T -> result valid from T+1.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    alu_sequencer_if.slave        bus,
    output state_e                state_dbg
);

    state_e            state;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] res_data_q;
    logic [ADDR_W-1:0] res_rd_q;
    logic              res_valid_q;
    logic [7:0]        op_count_q;

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    // Immediate loads write on the accept edge; ALU results write at the end
    // of EXEC, addressed by the destination latched at accept.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = bus.cmd_rd;
        rf_wd = bus.cmd_imm;
        if (state == ST_IDLE && bus.cmd_valid && bus.cmd_ld) begin
            rf_we = 1'b1;
        end else if (state == ST_EXEC) begin
            rf_we = 1'b1;
            rf_wa = res_rd_q;
            rf_wd = bus.alu_out;
        end
    end

    alu_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (bus.cmd_rs1),
        .rd1 (rf_rd1),
        .ra2 (bus.cmd_rs2),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        res_rd_q <= bus.cmd_rd;
                        if (bus.cmd_ld) begin
                            res_data_q  <= bus.cmd_imm;
                            res_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            alu_a_q  <= rf_rd1;
                            alu_b_q  <= rf_rd2;
                            alu_op_q <= bus.cmd_op;
                            state    <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    res_data_q  <= bus.alu_out;
                    res_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Held low while rst is asserted so every output reads 0 during reset.
    assign bus.cmd_ready = (state == ST_IDLE) && !rst;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.op_count  = op_count_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: bench-side 8-bit ALU, transaction-level model
// (register array, outstanding-result queue, cycle-stamped validity) and a
// per-cycle compare process, plus literal expectations for directed cases.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if bus();
    state_e state_dbg;

    alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Team 8-bit ALU
    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return p[7:0];
            4'd3:  return (b == 8'd0) ? 8'hFF : a / b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return ~a;
            4'd8:  return a;
            4'd9:  return b;
            4'd10: return a << b[2:0];
            4'd11: return a >> b[2:0];
            4'd12: return 8'($signed(a) >>> b[2:0]);
            4'd13: return a + 8'd4;
            4'd14: return a - 8'd4;
            default: return 8'($countones(a));
        endcase
    endfunction

    assign bus.alu_out = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

    // Scoreboard / model state
    logic [7:0] m_rf [4];
    logic [7:0] m_count;
    logic [7:0] m_alu_a, m_alu_b;
    logic [3:0] m_alu_op;
    logic [9:0] exp_q [$];
    bit         busy;
    bit         valid_now;
    bit         exp_v;
    int         cyc;
    int         valid_at;
    bit         chk_en;
    int         n_checks;
    int         n_pass;
    logic [7:0] last_data;
    logic [1:0] last_rd;
    logic [7:0] m_res;
    int         acc_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: one outstanding command; result valid one
    // cycle after accept for loads, two for ALU ops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
            m_count  = 8'd0;
            m_alu_a  = 8'd0;
            m_alu_b  = 8'd0;
            m_alu_op = 4'd0;
            busy     = 1'b0;
            exp_q.delete();
        end else begin
            valid_now = busy && (cyc >= valid_at);
            cyc++;
            if (valid_now && bus.res_ready) begin
                void'(exp_q.pop_front());
                busy    = 1'b0;
                m_count = m_count + 8'd1;
            end else if (!busy && bus.cmd_valid) begin
                if (bus.cmd_ld) begin
                    m_res    = bus.cmd_imm;
                    valid_at = cyc;
                end else begin
                    m_res    = alu_ref(bus.cmd_op, m_rf[bus.cmd_rs1], m_rf[bus.cmd_rs2]);
                    m_alu_a  = m_rf[bus.cmd_rs1];
                    m_alu_b  = m_rf[bus.cmd_rs2];
                    m_alu_op = bus.cmd_op;
                    valid_at = cyc + 1;
                end
                m_rf[bus.cmd_rd] = m_res;
                exp_q.push_back({bus.cmd_rd, m_res});
                busy = 1'b1;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            exp_v = busy && (cyc >= valid_at);
            chk("cmd_ready", bus.cmd_ready, !busy);
            chk("res_valid", bus.res_valid, exp_v);
            if (exp_v) begin
                chk("res_data", bus.res_data, exp_q[0][7:0]);
                chk("res_rd", bus.res_rd, exp_q[0][9:8]);
            end
            chk("op_count", bus.op_count, m_count);
            chk("alu_a", bus.alu_a, m_alu_a);
            chk("alu_b", bus.alu_b, m_alu_b);
            chk("alu_op", bus.alu_op, m_alu_op);
            if (bus.res_valid && bus.res_ready) begin
                last_data = bus.res_data;
                last_rd   = bus.res_rd;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic ld, input logic [7:0] imm);
        bit got;
        got = 1'b0;
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        bus.cmd_ld = ld; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk); #1;
                got = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) got = 1'b1;
        end
        if (!got) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    int  t0;
    bit  rand_done;

    initial begin
        n_checks = 0; n_pass = 0; chk_en = 1'b0; cyc = 0; valid_at = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_rd = 2'd0; bus.cmd_rs1 = 2'd0;
        bus.cmd_rs2 = 2'd0; bus.cmd_ld = 1'b0; bus.cmd_imm = 8'd0; bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_op_count", bus.op_count, 8'd0);
        chk("rst_alu_a", bus.alu_a, 8'd0);
        chk("rst_res_data", bus.res_data, 8'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;

        // LD r0=5, LD r1=3, ADD r2=r0+r1
        send(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'd5);
        send(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'd3);
        send(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
        wait_idle();
        chk("add_data", last_data, 8'h08);
        chk("add_rd", last_rd, 2'd2);
        chk("model_r2", m_rf[2], 8'h08);

        // SUB r3=r1-r0, LD r0=0x81, SRA r0=r0>>>r1
        send(OP_SUB, 2'd3, 2'd1, 2'd0, 1'b0, 8'd0);
        wait_idle();
        chk("sub_data", last_data, 8'hFE);
        send(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h81);
        send(OP_SRA, 2'd0, 2'd0, 2'd1, 1'b0, 8'd0);
        wait_idle();
        chk("sra_data", last_data, 8'hF0);
        chk("model_r0", m_rf[0], 8'hF0);

        // Downstream stall with a new command waiting upstream
        bus.res_ready = 1'b0;
        send(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h55);
        bus.cmd_op = OP_XOR; bus.cmd_rd = 2'd1; bus.cmd_rs1 = 2'd0; bus.cmd_rs2 = 2'd3;
        bus.cmd_ld = 1'b0; bus.cmd_imm = 8'd0; bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", bus.res_valid, 1'b1);
            chk("stall_data", bus.res_data, 8'h55);
            chk("stall_rd", bus.res_rd, 2'd3);
            chk("stall_ready", bus.cmd_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        send(OP_XOR, 2'd1, 2'd0, 2'd3, 1'b0, 8'd0);
        wait_idle();
        chk("xor_data", last_data, 8'hA5);
        chk("count_8", bus.op_count, 8'd8);

        // Reset while in EXEC
        send(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 8'd0);
        rst = 1'b1;
        #1;
        chk("exec_rst_state", state_dbg, ST_IDLE);
        chk("exec_rst_res_valid", bus.res_valid, 1'b0);
        chk("exec_rst_alu_a", bus.alu_a, 8'd0);
        chk("exec_rst_alu_b", bus.alu_b, 8'd0);
        chk("exec_rst_alu_op", bus.alu_op, 4'd0);
        chk("exec_rst_res_data", bus.res_data, 8'd0);
        chk("exec_rst_res_rd", bus.res_rd, 2'd0);
        chk("exec_rst_op_count", bus.op_count, 8'd0);
        chk("exec_rst_cmd_ready", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        send(OP_OR, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
        wait_idle();
        chk("rf_cleared", last_data, 8'd0);
        chk("count_1", bus.op_count, 8'd1);

        // 256 back-to-back loads: count wraps, 2 cycles each
        send(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'd0);
        t0 = acc_cyc;
        for (int i = 1; i < 256; i++) begin
            send(OP_ADD, 2'(i), 2'd0, 2'd0, 1'b1, 8'(i));
        end
        chk("b2b_cycles", acc_cyc - t0, 32'd510);
        wait_idle();
        chk("count_wrap", bus.op_count, 8'd1);

        // Random commands with random downstream back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.res_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        bus.res_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
